// File: rtl/stage5_scoreboard.sv
// Per-register pending-write scoreboard with RAW/WAW-full stall generation,
// write-back bypass, flush, sticky underflow detection and a drain (fence) FSM.
module stage5_scoreboard #(
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NWB       = 2,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [$clog2(NREGS)-1:0]      rs1_d,
  input  logic [$clog2(NREGS)-1:0]      rs2_d,
  input  logic                          issue_valid,
  input  logic                          issue_reg_write,
  input  logic [$clog2(NREGS)-1:0]      issue_rd,
  input  logic [NWB-1:0]                wb_valid,
  input  logic [NWB*$clog2(NREGS)-1:0]  wb_rd,
  input  logic                          flush,
  input  logic                          drain_req,
  output logic                          hazard_stall,
  output logic                          drain_ack,
  output logic                          empty,
  output logic                          underflow_err
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned DW = $clog2(NWB + 1);
  localparam int unsigned SW = ((CNT_W > DW) ? CNT_W : DW) + 1;

  typedef enum logic [0:0] {StIdle, StDrain} drain_st_e;

  drain_st_e        state_q, state_d;
  logic             drain_ack_q, drain_ack_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [DW-1:0]    ret_cnt [NREGS];
  logic [NREGS-1:0] pend;
  logic             issue_wr, waw_full, raw_hit, accept, under_any;

  // Number of write-back ports retiring each register this cycle.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      ret_cnt[r] = '0;
    end
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned p = 0; p < NWB; p++) begin
        if (wb_valid[p] && (wb_rd[p*RW +: RW] == RW'(r))) begin
          ret_cnt[r] = ret_cnt[r] + DW'(1);
        end
      end
    end
  end

  // A register whose last outstanding writes all retire this cycle is not pending under bypass.
  always_comb begin
    pend = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      pend[r] = (cnt_q[r] != '0) &&
                !(WB_BYPASS && (SW'(cnt_q[r]) == SW'(ret_cnt[r])));
    end
  end

  always_comb begin
    issue_wr     = issue_valid && issue_reg_write && (issue_rd != '0);
    waw_full     = issue_wr && (cnt_q[issue_rd] == '1) && (ret_cnt[issue_rd] == '0);
    raw_hit      = pend[rs1_d] || pend[rs2_d];
    hazard_stall = raw_hit || waw_full || (state_q == StDrain);
    accept       = issue_wr && !hazard_stall;
  end

  always_comb begin
    empty = 1'b1;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (cnt_q[r] != '0) empty = 1'b0;
    end
  end

  // Counter update: excess retires beyond the current count are dropped and flagged.
  always_comb begin
    logic [SW-1:0] cur;
    logic [SW-1:0] dec;
    logic [SW-1:0] inc;
    under_any = 1'b0;
    cnt_d[0]  = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      cur = SW'(cnt_q[r]);
      dec = SW'(ret_cnt[r]);
      inc = SW'(accept && (issue_rd == RW'(r)));
      if (dec > cur) begin
        under_any = 1'b1;
        dec       = cur;
      end
      cnt_d[r] = flush ? '0 : CNT_W'(cur + inc - dec);
    end
    underflow_d = underflow_q || (under_any && !flush);
  end

  always_comb begin
    state_d     = state_q;
    drain_ack_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (drain_req) begin
          if (empty) drain_ack_d = 1'b1;
          else       state_d     = StDrain;
        end
      end
      StDrain: begin
        if (empty) begin
          state_d     = StIdle;
          drain_ack_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      drain_ack_q <= 1'b0;
      underflow_q <= 1'b0;
      cnt_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      drain_ack_q <= drain_ack_d;
      underflow_q <= underflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign drain_ack     = drain_ack_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_stage5_scoreboard.sv
// Randomized plus directed bench for stage5_scoreboard against a counting reference model.
module tb_stage5_scoreboard;

  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int MAXC  = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [RW-1:0]   rs1_d, rs2_d, issue_rd;
  logic            issue_valid, issue_reg_write;
  logic [1:0]      wb_valid;
  logic [2*RW-1:0] wb_rd;
  logic            flush, drain_req;
  logic            hazard_stall, drain_ack, empty, underflow_err;

  stage5_scoreboard #(
    .NREGS     (NREGS),
    .NWB       (2),
    .CNT_W     (2),
    .WB_BYPASS (1'b1)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .rs1_d           (rs1_d),
    .rs2_d           (rs2_d),
    .issue_valid     (issue_valid),
    .issue_reg_write (issue_reg_write),
    .issue_rd        (issue_rd),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .flush           (flush),
    .drain_req       (drain_req),
    .hazard_stall    (hazard_stall),
    .drain_ack       (drain_ack),
    .empty           (empty),
    .underflow_err   (underflow_err)
  );

  always #5 CLK = ~CLK;

  int m_cnt [NREGS];
  bit m_under, m_drain, m_ack;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pending(input int r, input int c, input int rt);
    return (r != 0) && (c != 0) && (c != rt);
  endfunction

  task automatic model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_under = 0;
    m_drain = 0;
    m_ack   = 0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input bit rst, input bit iv, input bit iw, input int rd,
                      input int s1, input int s2, input bit v0, input int w0,
                      input bit v1, input int w1, input bit fl, input bit dr);
    int ret [NREGS];
    bit exp_stall, exp_empty, iwr, acc, nack;
    int d;
    RST             = rst;
    issue_valid     = iv;
    issue_reg_write = iw;
    issue_rd        = RW'(rd);
    rs1_d           = RW'(s1);
    rs2_d           = RW'(s2);
    wb_valid        = {v1, v0};
    wb_rd           = {RW'(w1), RW'(w0)};
    flush           = fl;
    drain_req       = dr;
    foreach (ret[r]) ret[r] = 0;
    if (v0 && w0 != 0) ret[w0]++;
    if (v1 && w1 != 0) ret[w1]++;
    exp_empty = 1;
    foreach (m_cnt[r]) if (m_cnt[r] != 0) exp_empty = 0;
    iwr       = iv && iw && (rd != 0);
    exp_stall = pending(s1, m_cnt[s1], ret[s1]) || pending(s2, m_cnt[s2], ret[s2]) ||
                (iwr && m_cnt[rd] == MAXC && ret[rd] == 0) || m_drain;
    acc       = iwr && !exp_stall;
    @(negedge CLK);
    check({tag, ".stall"}, int'(hazard_stall), int'(exp_stall));
    check({tag, ".empty"}, int'(empty), int'(exp_empty));
    check({tag, ".ack"}, int'(drain_ack), int'(m_ack));
    check({tag, ".underflow"}, int'(underflow_err), int'(m_under));
    @(posedge CLK);
    if (rst) begin
      model_reset();
    end else begin
      nack = 0;
      if (!m_drain && dr) begin
        if (exp_empty) nack = 1;
        else           m_drain = 1;
      end else if (m_drain && exp_empty) begin
        m_drain = 0;
        nack    = 1;
      end
      m_ack = nack;
      for (int r = 1; r < NREGS; r++) begin
        d = ret[r];
        if (d > m_cnt[r]) begin
          if (!fl) m_under = 1;
          d = m_cnt[r];
        end
        m_cnt[r] = fl ? 0 : m_cnt[r] + ((acc && rd == r) ? 1 : 0) - d;
      end
    end
    #1;
  endtask

  task automatic idle(input string tag, input int s1);
    step(tag, 0, 0, 0, 0, s1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input string tag, input int rd, input int s1);
    step(tag, 0, 1, 1, rd, s1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int rd, s1, s2, w0, w1;
    bit v0, v1;
    RST = 1'b1; issue_valid = 0; issue_reg_write = 0; issue_rd = '0;
    rs1_d = '0; rs2_d = '0; wb_valid = '0; wb_rd = '0; flush = 0; drain_req = 0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    idle("reset", 0);

    // Bypassed RAW on rd=5.
    issue("raw_issue", 5, 0);
    idle("raw_wait", 5);
    step("raw_bypass", 0, 0, 0, 0, 5, 0, 1, 5, 0, 0, 0, 0);
    idle("raw_clear", 5);

    // Counter saturation on rd=7, then issue accepted alongside a retire.
    issue("waw_a", 7, 0);
    issue("waw_b", 7, 0);
    issue("waw_c", 7, 0);
    issue("waw_full", 7, 0);
    step("waw_retire", 0, 1, 1, 7, 0, 0, 1, 7, 0, 0, 0, 0);
    issue("waw_still", 7, 0);
    step("waw_drop2", 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
    step("waw_drop1", 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);

    // Register 0 is never tracked.
    issue("x0_issue", 0, 0);
    idle("x0_after", 0);

    // Drain with two outstanding writes to rd=3.
    issue("drn_i1", 3, 0);
    issue("drn_i2", 3, 0);
    step("drn_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("drn_r1", 0, 1, 1, 6, 0, 0, 1, 3, 0, 0, 0, 0);
    step("drn_r2", 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle("drn_tail", 0);
    step("drn_fast", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("drn_fast_ack", 0);

    // Flush beats a simultaneous issue.
    issue("fl_pre", 4, 0);
    step("fl_flush", 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("fl_after", 4);

    // Reset in the middle of a drain gives no ack.
    issue("rstd_i", 2, 0);
    step("rstd_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("rstd_drain", 0);
    step("rstd_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("rstd_after", 2);
    idle("rstd_after2", 0);

    // Double retire of a single pending write is an underflow that sticks.
    issue("uf_issue", 9, 0);
    step("uf_double", 0, 0, 0, 0, 9, 0, 1, 9, 1, 9, 0, 0);
    idle("uf_sticky", 9);
    idle("uf_sticky2", 0);
    step("uf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rd = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      s2 = $urandom_range(0, 7);
      w0 = $urandom_range(0, 7);
      w1 = $urandom_range(0, 7);
      v0 = (m_cnt[w0] > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 60) == 0;
      v1 = (m_cnt[w1] > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 60) == 0;
      step("rnd", $urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, rd, s1, s2, v0, w0, v1, w1,
           $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage5_scoreboard.md
STAGE5_SCOREBOARD -- requirements
Module: stage5_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers tracked.
REQ-002 SHALL have parameter NWB, default 2, meaning number of write-back retire ports.
REQ-003 SHALL have parameter CNT_W, default 2, meaning per-register pending counter width (max 2^CNT_W-1 in flight).
REQ-004 SHALL have parameter WB_BYPASS, default 1, meaning a same-cycle retire of the last pending write clears the hazard.
REQ-005 SHALL have CLK  input  1  single clock; all state on rising edge.
REQ-006 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have rs1_d, rs2_d  input  clog2(NREGS) each  decode-stage source registers.
REQ-008 SHALL have issue_valid  input  1  decode instruction advancing to execute this cycle.
REQ-009 SHALL have issue_reg_write, issue_rd  input  1, clog2(NREGS)  issuing instruction writes issue_rd.
REQ-010 SHALL have wb_valid, wb_rd  input  NWB, NWB*clog2(NREGS)  retire of one pending write per port.
REQ-011 SHALL have flush  input  1  all in-flight writes squashed.
REQ-012 SHALL have drain_req  input  1  fence request: wait until nothing is pending.
REQ-013 SHALL have hazard_stall  output  1  decode must stall (RAW, WAW-full, or draining).
REQ-014 SHALL have drain_ack  output  1  one-cycle pulse, drain complete.
REQ-015 SHALL have empty  output  1  all counters zero.
REQ-016 SHALL have underflow_err  output  1  sticky: retire seen for a register with zero count.

Function
REQ-017 SHALL keep one CNT_W-bit counter per register; register 0 never tracked, its counter constant 0.
REQ-018 SHALL define pending(r) = cnt[r]!=0, except with WB_BYPASS=1 pending(r) is false when cnt[r] equals the number of wb ports retiring r this cycle.
REQ-019 SHALL assert hazard_stall combinationally when pending(rs1_d) or pending(rs2_d) (nonzero sources only).
REQ-020 SHALL assert hazard_stall when issue_valid & issue_reg_write & issue_rd!=0 and cnt[issue_rd] is at max (2^CNT_W-1) and not decremented this cycle.
REQ-021 SHALL accept an issue (increment cnt[issue_rd]) only when issue_valid & issue_reg_write & issue_rd!=0 & !hazard_stall.
REQ-022 SHALL decrement cnt[r] by the number of wb ports with wb_valid & wb_rd==r & r!=0, saturating at 0.
REQ-023 SHALL apply next = cnt + inc - dec in one cycle when issue and retire hit the same register; no loss, no double count.
REQ-024 SHALL set underflow_err when any retire targets r with cnt[r] less than the retire count for r; the excess is ignored; cleared only by RST.
REQ-025 SHALL on flush clear every counter next cycle; flush overrides issue and retire in the same cycle; late retires after flush hit REQ-024 only if the counter is zero.
REQ-026 SHALL implement drain FSM IDLE/DRAIN: IDLE->DRAIN on drain_req; DRAIN->IDLE when empty (registered), pulsing drain_ack for exactly that cycle.
REQ-027 SHALL if drain_req arrives while empty, pulse drain_ack the next cycle with no intermediate stall cycle.
REQ-028 SHALL assert hazard_stall throughout DRAIN, blocking new issues.
REQ-029 SHALL derive empty from registered counters (no same-cycle retire lookahead).

Reset
REQ-030 SHALL on RST at a clock edge clear all counters, the FSM to IDLE, drain_ack=0, underflow_err=0, empty=1, hazard_stall=0; RST mid-drain aborts without an ack.

Verification
REQ-031 SHALL cover: issue rd=5; next cycle rs1_d=5 -> hazard_stall=1; wb_rd[0]=5 same cycle with WB_BYPASS=1 -> stall=0 that cycle, cnt[5]=0 after.
REQ-032 SHALL cover: CNT_W=2, three issues to rd=7, fourth issue to rd=7 -> stall=1, cnt stays 3; retire of 7 same cycle -> issue accepted, cnt stays 3.
REQ-033 SHALL cover: both wb ports retire rd=9 with cnt[9]=1 -> cnt=0, underflow_err=1 and stays 1.
REQ-034 SHALL cover: issue_rd=0 with reg_write, rs1_d=0 -> no count, no stall.
REQ-035 SHALL cover: cnt[3]=2, drain_req -> stall=1; two retires of 3 -> drain_ack pulses once, stall drops next cycle.
REQ-036 SHALL cover: flush with simultaneous issue rd=4 -> all counters 0, empty=1 next cycle.
